// File: rtl/conv_mult_pipe.sv
// conv_mult_pipe: CHANNELS signed pixel*weight products through PIPE_STAGES elastic register stages.
// Latency: PIPE_STAGES cycles with out_ready high; one beat per cycle sustained.
// Backpressure: valid/ready; a stalled output holds, empty stages still fill, then in_ready drops.
// Optional MULT_SAT_EN: round half-up before the shift, saturate to signed OUT_W, sticky sat_flag.
module conv_mult_pipe #(
  parameter int DATA_W      = 8,
  parameter int COEF_W      = 8,
  parameter int CHANNELS    = 6,
  parameter int PIPE_STAGES = 2,
  parameter int SHIFT       = 0,
  parameter int OUT_W       = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DATA_W-1:0]   in_pix,
  input  logic [CHANNELS*COEF_W-1:0]   in_coef,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*OUT_W-1:0]    out_prod,
  output logic                         out_last,
  output logic                         sat_flag,
  output logic [15:0]                  beat_cnt,
  output logic                         frame_done
);

  localparam int PW  = DATA_W + COEF_W;
  localparam int SW  = ((PW > OUT_W) ? PW : OUT_W) + 2;
  localparam int NPD = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;

  logic [PIPE_STAGES-1:0]  r_vld;
  logic [PIPE_STAGES-1:0]  r_lst;
  logic [CHANNELS*PW-1:0]  r_pdat [NPD];
  logic [CHANNELS*OUT_W-1:0] r_out;
  logic [15:0]             r_cnt;

  logic [PIPE_STAGES-1:0]  w_ld;
  logic [PIPE_STAGES-1:0]  w_vin;
  logic [PIPE_STAGES-1:0]  w_lin;
  logic [CHANNELS*PW-1:0]  w_din [PIPE_STAGES];
  logic [CHANNELS*PW-1:0]  w_prod;
  logic [CHANNELS*PW-1:0]  w_fin;
  logic [CHANNELS*OUT_W-1:0] w_scaled;
  logic                    w_in_xfer;

  // full-precision signed lane products feeding stage 0
  always_comb begin
    logic signed [PW-1:0] v_a;
    logic signed [PW-1:0] v_b;
    v_a    = '0;
    v_b    = '0;
    w_prod = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      v_a = {{COEF_W{in_pix[i*DATA_W+DATA_W-1]}}, in_pix[i*DATA_W +: DATA_W]};
      v_b = {{DATA_W{in_coef[i*COEF_W+COEF_W-1]}}, in_coef[i*COEF_W +: COEF_W]};
      w_prod[i*PW +: PW] = v_a * v_b;
    end
  end

  // stage load enables: last stage drains on out_ready, earlier ones when the next loads
  always_comb begin
    logic v_l;
    w_ld = '0;
    v_l  = !r_vld[PIPE_STAGES-1] || out_ready;
    w_ld[PIPE_STAGES-1] = v_l;
    for (int s = PIPE_STAGES - 2; s >= 0; s--) begin
      v_l     = !r_vld[s] || v_l;
      w_ld[s] = v_l;
    end
  end

  // what each stage would capture: input port for stage 0, predecessor otherwise
  always_comb begin
    w_vin = '0;
    w_lin = '0;
    for (int s = 0; s < PIPE_STAGES; s++) w_din[s] = '0;
    w_vin[0] = in_valid;
    w_lin[0] = in_last;
    w_din[0] = w_prod;
    for (int s = 1; s < PIPE_STAGES; s++) begin
      w_vin[s] = r_vld[s-1];
      w_lin[s] = r_lst[s-1];
      w_din[s] = r_pdat[s-1];
    end
  end

  assign w_fin = w_din[PIPE_STAGES-1];

`ifdef MULT_SAT_EN
  localparam int                    RSH  = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [SW-1:0]  ONE  = 1;
  localparam logic signed [SW-1:0]  RND  = (SHIFT > 0) ? (ONE <<< RSH) : '0;
  localparam logic signed [SW-1:0]  MAXV = (ONE <<< (OUT_W - 1)) - ONE;
  localparam logic signed [SW-1:0]  MINV = -MAXV - ONE;
  logic w_sat_any;
  logic r_sat;

  // round half-up, shift, clamp each lane to the signed output range
  always_comb begin
    logic signed [SW-1:0] v_p;
    logic signed [SW-1:0] v_r;
    v_p       = '0;
    v_r       = '0;
    w_scaled  = '0;
    w_sat_any = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      v_p = {{(SW-PW){w_fin[i*PW+PW-1]}}, w_fin[i*PW +: PW]};
      v_r = (v_p + RND) >>> SHIFT;
      if (v_r > MAXV) begin
        w_scaled[i*OUT_W +: OUT_W] = MAXV[OUT_W-1:0];
        w_sat_any = 1'b1;
      end else if (v_r < MINV) begin
        w_scaled[i*OUT_W +: OUT_W] = MINV[OUT_W-1:0];
        w_sat_any = 1'b1;
      end else begin
        w_scaled[i*OUT_W +: OUT_W] = v_r[OUT_W-1:0];
      end
    end
  end

  // sticky saturation indicator, only reset clears it
  always_ff @(posedge clk) begin
    if (reset) r_sat <= 1'b0;
    else if (!flush && w_ld[PIPE_STAGES-1] && w_vin[PIPE_STAGES-1] && w_sat_any) r_sat <= 1'b1;
  end

  assign sat_flag = r_sat;
`else
  // truncating arithmetic shift, keep the low OUT_W bits of each lane
  always_comb begin
    logic signed [SW-1:0] v_p;
    logic signed [SW-1:0] v_r;
    v_p      = '0;
    v_r      = '0;
    w_scaled = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      v_p = {{(SW-PW){w_fin[i*PW+PW-1]}}, w_fin[i*PW +: PW]};
      v_r = v_p >>> SHIFT;
      w_scaled[i*OUT_W +: OUT_W] = v_r[OUT_W-1:0];
    end
  end

  assign sat_flag = 1'b0;
`endif

  // stage valid/last tags; flush empties the pipe, reset also clears the last tags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
      r_lst <= '0;
    end else begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        if (flush) begin
          r_vld[s] <= 1'b0;
        end else if (w_ld[s]) begin
          r_vld[s] <= w_vin[s];
          if (w_vin[s]) r_lst[s] <= w_lin[s];
        end
      end
    end
  end

  // intermediate product registers, captured only for valid beats
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NPD; s++) r_pdat[s] <= '0;
    end else if (!flush) begin
      for (int s = 0; s < PIPE_STAGES - 1; s++) begin
        if (w_ld[s] && w_vin[s]) r_pdat[s] <= w_din[s];
      end
    end
  end

  // output stage holds scaled lanes; keeps its value while invalid
  always_ff @(posedge clk) begin
    if (reset) r_out <= '0;
    else if (!flush && w_ld[PIPE_STAGES-1] && w_vin[PIPE_STAGES-1]) r_out <= w_scaled;
  end

  assign w_in_xfer = in_valid && w_ld[0] && !flush;

  // per-frame count of accepted input beats, restarts after a last beat
  always_ff @(posedge clk) begin
    if (reset) r_cnt <= '0;
    else if (w_in_xfer) r_cnt <= in_last ? 16'd0 : r_cnt + 16'd1;
  end

  assign in_ready   = w_ld[0];
  assign out_valid  = r_vld[PIPE_STAGES-1];
  assign out_last   = r_lst[PIPE_STAGES-1];
  assign out_prod   = r_out;
  assign beat_cnt   = r_cnt;
  assign frame_done = !reset && !flush && r_vld[PIPE_STAGES-1] && out_ready && r_lst[PIPE_STAGES-1];

endmodule

// File: tb/tb_conv_mult_pipe.sv
// Bench for conv_mult_pipe: default instance plus a 4-stage, SHIFT=4, OUT_W=8 instance.
// Scoreboard queues hold expected beats pushed on input handshakes, popped on output transfers.
module tb_conv_mult_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_valid2, in_last, out_ready;
  logic        out_ready2 = 1'b1;
  logic [47:0] in_pix, in_coef;
  logic        in_ready, out_valid, out_last, sat_flag, frame_done;
  logic [15:0] beat_cnt;
  logic [95:0] out_prod;
  logic        in_ready2, out_valid2, out_last2, sat_flag2, frame_done2;
  logic [15:0] beat_cnt2;
  logic [47:0] out_prod2;

  int cyc = 0;
  int rdy_mode = 0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_mult_pipe u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pix(in_pix), .in_coef(in_coef), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_prod(out_prod), .out_last(out_last), .sat_flag(sat_flag),
    .beat_cnt(beat_cnt), .frame_done(frame_done)
  );

  conv_mult_pipe #(.PIPE_STAGES(4), .SHIFT(4), .OUT_W(8)) u_dut2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_pix(in_pix), .in_coef(in_coef), .in_last(in_last), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_prod(out_prod2), .out_last(out_last2), .sat_flag(sat_flag2),
    .beat_cnt(beat_cnt2), .frame_done(frame_done2)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] rnd48();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[47:0];
  endfunction

  // exact 16-bit products for the default instance
  function automatic logic [95:0] mdl_main(input logic [47:0] p, input logic [47:0] c);
    logic [95:0] r;
    int a, b, m;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      a = int'($signed(p[i*8 +: 8]));
      b = int'($signed(c[i*8 +: 8]));
      m = a * b;
      r[i*16 +: 16] = m[15:0];
    end
    return r;
  endfunction

  // SHIFT=4, OUT_W=8 instance; bit 48 flags a saturating lane
  function automatic logic [48:0] mdl_sc(input logic [47:0] p, input logic [47:0] c);
    logic [48:0] r;
    int a, b, m;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      a = int'($signed(p[i*8 +: 8]));
      b = int'($signed(c[i*8 +: 8]));
`ifdef MULT_SAT_EN
      m = (a * b + 8) >>> 4;
      if (m > 127) begin m = 127; r[48] = 1'b1; end
      if (m < -128) begin m = -128; r[48] = 1'b1; end
`else
      m = (a * b) >>> 4;
`endif
      r[i*8 +: 8] = m[7:0];
    end
    return r;
  endfunction

  // downstream ready pattern, applied just after each rising edge
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // scoreboard and protocol monitor for the default instance
  logic [96:0] q1 [$];
  int          exp_cnt = 0;
  int          fd_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [95:0] prev_prod;
  logic        prev_last;

  always @(negedge clk) begin
    logic [96:0] e;
    if (reset) begin
      q1.delete();
      exp_cnt    = 0;
      prev_stall = 1'b0;
    end else begin
      check_eq("beat_cnt", beat_cnt, exp_cnt[15:0]);
      if (frame_done) fd_cnt++;
      if (prev_stall && out_valid) begin
        check_eq("stall_prod", out_prod, prev_prod);
        check_eq("stall_last", out_last, prev_last);
      end
      if (out_valid && out_ready && !flush) begin
        check_eq("sb_nonempty", q1.size() > 0, 1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          check_eq("out_prod", out_prod, e[95:0]);
          check_eq("out_last", out_last, e[96]);
          check_eq("frame_done", frame_done, e[96]);
        end
      end else begin
        check_eq("frame_done_idle", frame_done, 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_prod  = out_prod;
      prev_last  = out_last;
      if (flush) begin
        q1.delete();
      end else if (in_valid && in_ready) begin
        q1.push_back({in_last, mdl_main(in_pix, in_coef)});
        exp_cnt = in_last ? 0 : (exp_cnt + 1) % 65536;
      end
    end
  end

  // scoreboard for the scaled 4-stage instance
  logic [48:0] q2 [$];
  int          first_a2 = -1, first_o2 = -1, last_o2 = -1, n_o2 = 0;
  logic [47:0] first_prod2 = '0;
  logic        exp_sat2 = 1'b0;

  always @(negedge clk) begin
    logic [48:0] e;
    if (reset) begin
      q2.delete();
    end else begin
      if (out_valid2) begin
        check_eq("sb2_nonempty", q2.size() > 0, 1);
        if (q2.size() > 0) begin
          e = q2.pop_front();
          check_eq("out_prod2", out_prod2, e[47:0]);
        end
        if (first_o2 < 0) begin
          first_o2    = cyc;
          first_prod2 = out_prod2;
        end
        last_o2 = cyc;
        n_o2++;
      end
      if (flush) begin
        q2.delete();
      end else if (in_valid2 && in_ready2) begin
        e = mdl_sc(in_pix, in_coef);
        q2.push_back(e);
        if (e[48]) exp_sat2 = 1'b1;
        if (first_a2 < 0) first_a2 = cyc;
      end
    end
  end

  // offer one beat (caller sits just after a rising edge); valid stays high on return
  task automatic send(input logic [47:0] p, input logic [47:0] c, input logic l);
    int n;
    n = 0;
    in_pix   = p;
    in_coef  = c;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("send_timeout", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_acc, fd0, cnt0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
    in_last = 1'b0; in_pix = '0; in_coef = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_prod", out_prod, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_sat_flag", sat_flag, 0);
    check_eq("rst_beat_cnt", beat_cnt, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid2", out_valid2, 0);

    // single beat, exact two-cycle latency and known products
    @(posedge clk); #1;
    in_pix   = {8'hF9, 8'h05, 8'h00, 8'hFF, 8'h7F, 8'h80};
    in_coef  = {8'h03, 8'h05, 8'h63, 8'hFF, 8'h80, 8'h80};
    in_last  = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    check_eq("t1_accept", in_ready, 1);
    check_eq("t1_lat0", out_valid, 0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check_eq("t1_lat1", out_valid, 0);
    @(negedge clk);
    check_eq("t1_lat2", out_valid, 1);
    check_eq("t1_prod", out_prod, {16'hFFEB, 16'h0019, 16'h0000, 16'h0001, 16'hC080, 16'h4000});
    @(negedge clk);
    check_eq("t1_lat3", out_valid, 0);
    check_eq("t1_cnt", beat_cnt, 1);

    // 20-beat frame under a 1,0,0,1 ready pattern
    @(posedge clk); #1;
    fd0 = fd_cnt;
    rdy_mode = 1;
    for (int k = 1; k <= 20; k++) send(rnd48(), rnd48(), k == 20);
    in_valid = 1'b0;
    rdy_mode = 0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check_eq("t2_drain", q1.size(), 0);
    check_eq("t2_frame_done", fd_cnt - fd0, 1);
    check_eq("t2_cnt", beat_cnt, 0);

    // fill with downstream stalled, then drain
    @(posedge clk); #1;
    rdy_mode = 2;
    n_acc = 0;
    for (int k = 0; k < 6; k++) begin
      in_pix = rnd48(); in_coef = rnd48(); in_last = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      if (!in_ready) break;
      n_acc++;
      @(posedge clk); #1;
    end
    check_eq("t3_fill_count", n_acc, 2);
    check_eq("t3_full_ready", in_ready, 0);
    check_eq("t3_full_valid", out_valid, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rdy_mode = 0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_eq("t3_drain", q1.size(), 0);

    // flush with two beats in flight
    @(posedge clk); #1;
    rdy_mode = 2;
    send(rnd48(), rnd48(), 1'b0);
    send(rnd48(), rnd48(), 1'b0);
    in_valid = 1'b0;
    cnt0 = exp_cnt;
    fd0  = fd_cnt;
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check_eq("t4_valid", out_valid, 0);
    check_eq("t4_in_ready", in_ready, 1);
    check_eq("t4_cnt", beat_cnt, cnt0[15:0]);
    @(posedge clk); #1 rdy_mode = 0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_eq("t4_no_frame_done", fd_cnt - fd0, 0);
    check_eq("t4_no_output", q1.size(), 0);

    // reset mid-stream
    @(posedge clk); #1;
    rdy_mode = 2;
    send(48'h0102_0304_0506, 48'h0708_090A_0B0C, 1'b1);
    send(rnd48(), rnd48(), 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_eq("t5_valid", out_valid, 0);
    check_eq("t5_prod", out_prod, 0);
    check_eq("t5_last", out_last, 0);
    check_eq("t5_cnt", beat_cnt, 0);
    check_eq("t5_frame_done", frame_done, 0);
    check_eq("t5_in_ready", in_ready, 1);
    @(posedge clk); #1 rdy_mode = 0;

    // 4-stage scaled instance: latency, 50-beat throughput, scaling corner cases
    @(posedge clk); #1;
    for (int k = 0; k < 50; k++) begin
      if (k == 0) begin
        in_pix  = 48'h0000_0000_0A80;
        in_coef = 48'h0000_0000_0C80;
      end else begin
        in_pix  = rnd48();
        in_coef = rnd48();
      end
      in_last   = 1'b0;
      in_valid2 = 1'b1;
      @(posedge clk); #1;
    end
    in_valid2 = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("t6_latency", first_o2 - first_a2, 4);
    check_eq("t6_count", n_o2, 50);
    check_eq("t6_throughput", last_o2 - first_o2, 49);
    check_eq("t6_drain", q2.size(), 0);
`ifdef MULT_SAT_EN
    check_eq("t6_lane0", first_prod2[7:0], 8'h7F);
    check_eq("t6_lane1", first_prod2[15:8], 8'h08);
    check_eq("t6_sat_flag", sat_flag2, 1);
`else
    check_eq("t6_lane0", first_prod2[7:0], 8'h00);
    check_eq("t6_lane1", first_prod2[15:8], 8'h07);
    check_eq("t6_sat_flag", sat_flag2, 0);
`endif
    check_eq("t6_sat_model", sat_flag2, exp_sat2);
    check_eq("main_sat_flag", sat_flag, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
